// File: rtl/systolic_array_ws.sv
// Weight-stationary N x N systolic array with skewed input and de-skewed rows.
// Define SA_SATURATE_EN to clamp results to DW; otherwise results wrap.
module systolic_array_ws #(
  parameter int N  = 10,
  parameter int DW = 16,
  parameter int AW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            reload,
  input  logic [7:0]      len,
  input  logic [4:0]      shift,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [N*DW-1:0] w_data,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [N*DW-1:0] a_data,
  output logic            r_valid,
  input  logic            r_ready,
  output logic [N*DW-1:0] r_data,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(N);
  localparam int L  = 2*N+2;

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, DRAIN, DONE
  } state_t;

  state_t state, state_n;

  logic [7:0]    len_q;
  logic [7:0]    in_cnt;
  logic [7:0]    out_cnt;
  logic [4:0]    sh_q;
  logic [CW-1:0] w_cnt;

  logic stall, adv;
  logic w_hs, a_hs, r_hs;

  logic [L-1:0] vp;

  logic signed [DW-1:0] wt  [N][N];
  logic signed [DW-1:0] sk  [N][N];
  logic signed [DW-1:0] ar  [N][N];
  logic signed [DW-1:0] ain [N][N];
  logic signed [AW-1:0] pr  [N][N];
  logic signed [AW-1:0] pin [N][N];
  logic signed [AW-1:0] dk  [N][N-1];
  logic signed [AW-1:0] col [N];
  logic [DW-1:0]        red [N];
  logic [DW-1:0]        sh_r [N];

  assign stall   = r_valid && !r_ready;
  assign adv     = !stall;
  assign w_hs    = w_valid && w_ready;
  assign a_hs    = a_valid && a_ready;
  assign r_hs    = r_valid && r_ready;
  assign r_valid = vp[L-1];
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state and handshake readiness
  always_comb begin
    state_n = state;
    w_ready = 1'b0;
    a_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = reload ? LOAD : RUN;
      end
      LOAD: begin
        w_ready = 1'b1;
        if (w_valid && w_cnt == CW'(N-1))
          state_n = (len_q == 8'd0) ? DONE : RUN;
      end
      RUN: begin
        if (len_q == 8'd0) begin
          state_n = DONE;
        end else begin
          a_ready = !stall;
          if (a_valid && !stall &&
              in_cnt == len_q - 8'd1)
            state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (r_valid && r_ready &&
            out_cnt == len_q - 8'd1)
          state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Job parameters and beat/row counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q   <= '0;
      sh_q    <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      w_cnt   <= '0;
    end else begin
      if (state == IDLE && start) begin
        len_q   <= len;
        sh_q    <= shift;
        in_cnt  <= '0;
        out_cnt <= '0;
        w_cnt   <= '0;
      end else begin
        if (w_hs) w_cnt   <= w_cnt + 1'b1;
        if (a_hs) in_cnt  <= in_cnt + 8'd1;
        if (r_hs) out_cnt <= out_cnt + 8'd1;
      end
    end
  end

  // Stationary weights, one row per load beat
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          wt[i][j] <= '0;
    end else if (w_hs) begin
      for (int j = 0; j < N; j++)
        wt[w_cnt][j] <= w_data[j*DW +: DW];
    end
  end

  // PE operands: activations move right, sums move down
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ain[i][0] = sk[i][i];
      for (int j = 1; j < N; j++)
        ain[i][j] = ar[i][j-1];
    end
    for (int j = 0; j < N; j++) begin
      pin[0][j] = '0;
      for (int i = 1; i < N; i++)
        pin[i][j] = pr[i-1][j];
    end
  end

  // Column j leaves the array j cycles late; realign
  always_comb begin
    for (int j = 0; j < N-1; j++)
      col[j] = dk[j][N-2-j];
    col[N-1] = pr[N-1][N-1];
  end

`ifdef SA_SATURATE_EN
  localparam logic signed [AW-1:0] MAXV =
    {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0] sv [N];

  // Floor-shift then clamp into DW signed range
  always_comb begin
    for (int j = 0; j < N; j++) begin
      sv[j] = col[j] >>> sh_q;
      if (sv[j] > MAXV)
        red[j] = MAXV[DW-1:0];
      else if (sv[j] < MINV)
        red[j] = MINV[DW-1:0];
      else
        red[j] = sv[j][DW-1:0];
    end
  end
`else
  // Floor-shift then keep the low DW bits
  always_comb begin
    for (int j = 0; j < N; j++)
      red[j] = DW'(col[j] >>> sh_q);
  end
`endif

  // Whole datapath advances together, frozen on stall
  always_ff @(posedge clk) begin
    if (!rst) begin
      vp     <= '0;
      r_data <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          sk[i][j] <= '0;
          ar[i][j] <= '0;
          pr[i][j] <= '0;
        end
        for (int d = 0; d < N-1; d++)
          dk[i][d] <= '0;
        sh_r[i] <= '0;
      end
    end else if (adv) begin
      vp <= {vp[L-2:0], a_hs};
      for (int i = 0; i < N; i++) begin
        sk[i][0] <= a_hs ? a_data[i*DW +: DW] : '0;
        for (int d = 1; d < N; d++)
          sk[i][d] <= sk[i][d-1];
      end
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          ar[i][j] <= ain[i][j];
          pr[i][j] <= pin[i][j] +
            AW'(ain[i][j]) * AW'(wt[i][j]);
        end
      end
      for (int j = 0; j < N; j++) begin
        dk[j][0] <= pr[N-1][j];
        for (int d = 1; d < N-1; d++)
          dk[j][d] <= dk[j][d-1];
        sh_r[j] <= red[j];
        r_data[j*DW +: DW] <= sh_r[j];
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_ws.sv
// Directed bench for systolic_array_ws, N=4 DW=16 AW=32.
// Result rows, latency, stall, reuse, len=0 and reset cases.
module tb_systolic_array_ws;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          reload = 1'b0;
  logic [7:0]    len = '0;
  logic [4:0]    shift = '0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [N*DW-1:0] w_data = '0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [N*DW-1:0] a_data = '0;
  logic          r_valid;
  logic          r_ready = 1'b1;
  logic [N*DW-1:0] r_data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  systolic_array_ws #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .start(start), .reload(reload),
    .len(len), .shift(shift),
    .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_data(a_data),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_data(r_data),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int wr_cnt = 0;

  logic [63:0] rq [$];
  int          rc [$];
  int          aq [$];
  int          vq [$];

  logic [63:0] wrow [4];
  logic [63:0] arow [$];
  logic [63:0] erow [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done)    done_cnt <= done_cnt + 1;
    if (w_ready) wr_cnt   <= wr_cnt + 1;
    if (a_valid && a_ready) aq.push_back(cyc);
    if (r_valid) vq.push_back(cyc);
    if (r_valid && r_ready) begin
      rq.push_back(r_data);
      rc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  function automatic logic [63:0] pk(
    int e0, int e1, int e2, int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_diag(input int v);
    for (int i = 0; i < N; i++) begin
      logic [63:0] r;
      r = '0;
      r[i*DW +: DW] = 16'(v);
      wrow[i] = r;
    end
  endtask

  task automatic clear_q();
    rq.delete();
    rc.delete();
    aq.delete();
    vq.delete();
  endtask

  task automatic run_job(input string tag,
                         input logic rl,
                         input int ln,
                         input int sh);
    int t;
    int d0;
    clear_q();
    d0 = done_cnt;
    start  = 1'b1;
    reload = rl;
    len    = 8'(ln);
    shift  = 5'(sh);
    step();
    start = 1'b0;
    if (rl) begin
      for (int i = 0; i < N; i++) begin
        w_data  = wrow[i];
        w_valid = 1'b1;
        t = 0;
        while (!w_ready && t < 200) begin
          step();
          t++;
        end
        if (t >= 200) chk({tag, "_wto"}, 0, 1);
        step();
      end
      w_valid = 1'b0;
    end
    for (int k = 0; k < ln; k++) begin
      a_data  = arow[k];
      a_valid = 1'b1;
      t = 0;
      while (!a_ready && t < 200) begin
        step();
        t++;
      end
      if (t >= 200) chk({tag, "_ato"}, 0, 1);
      step();
    end
    a_valid = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 300) begin
      step();
      t++;
    end
    if (t >= 300) chk({tag, "_dto"}, 0, 1);
    repeat (4) step();
    chk({tag, "_done"}, done_cnt - d0, 1);
  endtask

  task automatic check_rows(input string tag);
    chk({tag, "_n"}, rq.size(), erow.size());
    for (int i = 0; i < erow.size(); i++)
      if (i < rq.size())
        chk($sformatf("%s_r%0d", tag, i), rq[i], erow[i]);
  endtask

  task automatic stall_proc();
    int t;
    logic [63:0] snap;
    t = 0;
    while (!r_valid && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) chk("stall_to", 0, 1);
    r_ready = 1'b0;
    snap = r_data;
    repeat (5) begin
      step();
      chk("stall_ardy", a_ready, 0);
      chk("stall_rv", r_valid, 1);
      chk("stall_data", r_data, snap);
    end
    r_ready = 1'b1;
  endtask

  initial begin
    int d0;
    int w0;
    logic [63:0] e_hi;
    logic [63:0] e_lo;

    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_rv", r_valid, 0);
    chk("rst_wrdy", w_ready, 0);
    chk("rst_ardy", a_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", r_data, 0);
    rst = 1'b1;
    step();

    set_diag(1);
    arow = '{pk(1,2,3,4), pk(5,6,7,8),
             pk(-1,-2,-3,-4)};
    erow = arow;
    run_job("ident", 1'b1, 3, 0);
    check_rows("ident");
    if (vq.size() > 0 && aq.size() > 0)
      chk("latency", vq[0] - aq[0] - 1, 9);
    else
      chk("latency_seen", 0, 1);

    fork
      run_job("stall", 1'b1, 3, 0);
      stall_proc();
    join
    check_rows("stall");

    set_diag(2);
    arow = '{pk(1,1,1,1)};
    erow = '{pk(2,2,2,2)};
    run_job("w2", 1'b1, 1, 0);
    check_rows("w2");
    w0 = wr_cnt;
    run_job("reuse", 1'b0, 1, 0);
    check_rows("reuse");
    chk("reuse_wrdy", wr_cnt - w0, 0);

    arow = '{pk(-3,3,-1,5)};
    erow = '{pk(-2,1,-1,2)};
    run_job("shr2", 1'b0, 1, 2);
    check_rows("shr2");

    for (int i = 0; i < N; i++)
      wrow[i] = pk(4*i, 4*i+1, 4*i+2, 4*i+3);
    arow = '{pk(1,2,3,4), pk(1,0,0,-1)};
    erow = '{pk(80,90,100,110),
             pk(-12,-12,-12,-12)};
    run_job("gen", 1'b1, 2, 0);
    check_rows("gen");
    if (rc.size() == 2)
      chk("b2b", rc[1] - rc[0], 1);
    else
      chk("b2b_n", rc.size(), 2);

`ifdef SA_SATURATE_EN
    e_hi = pk(32767, 32767, 32767, 32767);
    e_lo = pk(-32768, -32768, -32768, -32768);
`else
    e_hi = pk(0, 0, 0, 0);
    e_lo = pk(0, 0, 0, 0);
`endif
    for (int i = 0; i < N; i++)
      wrow[i] = pk(16384, 16384, 16384, 16384);
    arow = '{pk(16384, 16384, 16384, 16384),
             pk(-16384, -16384, -16384, -16384)};
    erow = '{e_hi, e_lo};
    run_job("ovf", 1'b1, 2, 0);
    check_rows("ovf");
    arow = '{pk(16384, 16384, 16384, 16384)};
    erow = '{pk(16384, 16384, 16384, 16384)};
    run_job("shr16", 1'b0, 1, 16);
    check_rows("shr16");

    clear_q();
    start  = 1'b1;
    reload = 1'b0;
    len    = 8'd0;
    step();
    start = 1'b0;
    chk("len0_busy", busy, 1);
    chk("len0_d0", done, 0);
    step();
    chk("len0_d1", done, 1);
    step();
    chk("len0_d2", done, 0);
    chk("len0_idle", busy, 0);
    repeat (12) step();
    chk("len0_rv", vq.size(), 0);

    arow = '{pk(1,2,3,4), pk(5,6,7,8),
             pk(-1,-2,-3,-4)};
    start  = 1'b1;
    reload = 1'b0;
    len    = 8'd3;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_data  = arow[k];
      a_valid = 1'b1;
      step();
    end
    a_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("mid_busy", busy, 0);
    chk("mid_rv", r_valid, 0);
    chk("mid_rdata", r_data, 0);
    chk("mid_done", done, 0);
    rst = 1'b1;
    clear_q();
    d0 = done_cnt;
    repeat (20) step();
    chk("mid_norv", vq.size(), 0);
    chk("mid_nodone", done_cnt - d0, 0);

    set_diag(1);
    erow = arow;
    run_job("post", 1'b1, 3, 0);
    check_rows("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_array_ws.md
SYSTOLIC_ARRAY_WS -- requirements
Module: systolic_array_ws

Interface
REQ-001 SHALL have parameter N, default 10: array dimension (N x N PEs), legal 2..16.
REQ-002 SHALL have parameter DW, default 16: signed data/weight/result width.
REQ-003 SHALL have parameter AW, default 32: signed accumulator width, AW >= 2*DW.
REQ-004 SHALL have port clk, input, 1: single clock, all logic rising-edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-low reset.
REQ-006 SHALL have port start, input, 1: job request, sampled in IDLE only.
REQ-007 SHALL have port reload, input, 1: sampled with start; 1 = load new weights, 0 = reuse held weights.
REQ-008 SHALL have port len, input, 8: number of A rows in job, sampled with start.
REQ-009 SHALL have port shift, input, 5: result right-shift amount, sampled with start.
REQ-010 SHALL have ports w_valid in 1, w_ready out 1, w_data in N*DW: weight row stream, element j at bits [j*DW +: DW].
REQ-011 SHALL have ports a_valid in 1, a_ready out 1, a_data in N*DW: activation row stream, same packing.
REQ-012 SHALL have ports r_valid out 1, r_ready in 1, r_data out N*DW: result row stream, same packing.
REQ-013 SHALL have ports busy out 1 (state != IDLE) and done out 1 (one-cycle job-complete pulse).

Function
REQ-014 SHALL compute R[k][j] = sum over i of A[k][i]*W[i][j], weight-stationary, one A row per a_valid&&a_ready handshake.
REQ-015 SHALL implement states IDLE, LOAD, RUN, DRAIN, DONE.
REQ-016 IDLE: start=1 with reload=1 -> LOAD; start=1 with reload=0 -> RUN; start in any other state ignored.
REQ-017 LOAD: w_ready=1; accept exactly N beats, beat i written to weight row i; after beat N-1 -> RUN (or DONE if len=0).
REQ-018 RUN: a_ready = !stall; accept exactly len rows, then -> DRAIN; len=0 -> DONE directly.
REQ-019 DRAIN: a_ready=0; remain until last result row handshaken on r_valid&&r_ready, then -> DONE.
REQ-020 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-021 Input SHALL be internally skewed (column i delayed i cycles) and output de-skewed so r_data is one coherent row.
REQ-022 Latency without stall SHALL be exactly 2N+1 cycles from A-row handshake to r_valid for that row; rows emerge in input order.
REQ-023 Products SHALL be full 2*DW signed, accumulated in AW signed with wrap on AW overflow.
REQ-024 Output element SHALL be accumulator arithmetically right-shifted by shift (truncation toward minus infinity), then reduced to DW per REQ-030/031.
REQ-025 stall = r_valid && !r_ready; while stall, entire pipeline (skew, PEs, de-skew, output) SHALL hold and r_data SHALL stay stable.
REQ-026 Weights SHALL be held unchanged across jobs until the next LOAD.
REQ-027 Back-to-back accepted rows with r_ready=1 SHALL sustain one result row per cycle.

Reset
REQ-028 rst=0 at a clock edge SHALL force: state IDLE, all weights 0, all pipeline registers 0, w_ready=0, a_ready=0, r_valid=0, r_data=0, busy=0, done=0.
REQ-029 Reset mid-job SHALL discard all in-flight rows; no r_valid or done after reset release until a new start.

Configuration
REQ-030 With macro SA_SATURATE_EN defined, shifted value outside DW signed range SHALL clamp to max (2^(DW-1)-1) or min (-2^(DW-1)).
REQ-031 Without SA_SATURATE_EN, shifted value SHALL be truncated to its low DW bits (two's-complement wrap).

Verification
REQ-032 N=4, reload=1, W=identity, len=3, shift=0, A rows {1,2,3,4},{5,6,7,8},{-1,-2,-3,-4} -> R rows equal A rows, first r_valid 9 cycles after first A handshake, one done pulse.
REQ-033 Same job with r_ready held 0 for 5 cycles after first r_valid -> a_ready=0 and r_data stable during stall, no row lost or duplicated.
REQ-034 N=4, W all 16384, A all 16384, shift=0 -> SA_SATURATE_EN: every element 32767; without it: low 16 bits of 2^30 (value 0).
REQ-035 Job with reload=1 weights W=2*I, then job with reload=0, A row {1,1,1,1} -> R row {2,2,2,2}, no w_ready in second job.
REQ-036 len=0 with reload=0 -> done pulse one cycle after RUN entry, no r_valid ever.
REQ-037 rst=0 asserted 3 cycles into RUN with rows in flight -> next cycle busy=0, r_valid=0; subsequent job with identity weights reloaded produces correct results.
